// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
//   uart_data_t      : one UART byte
//   uart_arb_state_e : frame-level arbiter FSM states
//   BURST_W / GAP_W  : widths of the per-grant byte and idle counters
package uart_tx_arbiter_pkg;

  typedef logic [7:0] uart_data_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACC,
    WAIT_DONE,
    RELEASE
  } uart_arb_state_e;

  localparam int BURST_W = 8;
  localparam int GAP_W   = 10;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index of the last winner; search starts at ptr_i+1 and wraps
//   gnt_oh_o  : one-hot winner
//   gnt_idx_o : binary winner index
//   any_o     : at least one request present
// The pointer register lives in the parent.
module uart_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   ptr_i,
  output logic [N_REQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]   gnt_idx_o,
  output logic             any_o
);

  always_comb begin
    logic [IDW-1:0] idx;
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = '0;
    // Walk ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins.
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[idx]) begin
        any_o         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters with
// frame-granular round-robin arbitration.
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/data/last : per-requester byte stream
//   req_ready           : one-hot accept pulse (only in LOAD, only to owner)
//   uart_tx_data        : byte to transmitter, stable from SEND to next accept
//   uart_send           : one-cycle send strobe
//   uart_tx_data_ready  : transmitter idle
//   grant_valid/id      : current owner
//   drop_timeout        : pulse when a grant is released for inactivity
// A grant ends on a last byte, after MAX_BURST bytes, or after GAP_TIMEOUT
// idle LOAD cycles.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int MAX_BURST   = 16,
  parameter  int GAP_TIMEOUT = 64,
  localparam int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic       [N_REQ-1:0] req_valid,
  input  uart_data_t [N_REQ-1:0] req_data,
  input  logic       [N_REQ-1:0] req_last,
  output logic       [N_REQ-1:0] req_ready,
  output uart_data_t             uart_tx_data,
  output logic                   uart_send,
  input  logic                   uart_tx_data_ready,
  output logic                   grant_valid,
  output logic       [IDW-1:0]   grant_id,
  output logic                   drop_timeout
);

  uart_arb_state_e     state_q, state_d;
  logic [IDW-1:0]      gid_q, gid_d;
  logic [N_REQ-1:0]    goh_q, goh_d;
  logic                gvalid_q, gvalid_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                last_q, last_d;
  uart_data_t          txd_q, txd_d;
  logic                drop_q, drop_d;
  logic [IDW-1:0]      rr_q, rr_d;

  logic [N_REQ-1:0]    pick_oh;
  logic [IDW-1:0]      pick_idx;
  logic                pick_any;
  logic                sel_valid;
  logic                accept;

  uart_rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_rr (
    .req_i     (req_valid),
    .ptr_i     (rr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx),
    .any_o     (pick_any)
  );

  // Only the owner's lane is looked at while a grant is held.
  assign sel_valid = |(req_valid & goh_q);
  assign accept    = (state_q == LOAD) && sel_valid && uart_tx_data_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      goh_q    <= '0;
      gvalid_q <= 1'b0;
      burst_q  <= '0;
      gap_q    <= '0;
      last_q   <= 1'b0;
      txd_q    <= '0;
      drop_q   <= 1'b0;
      rr_q     <= IDW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      goh_q    <= goh_d;
      gvalid_q <= gvalid_d;
      burst_q  <= burst_d;
      gap_q    <= gap_d;
      last_q   <= last_d;
      txd_q    <= txd_d;
      drop_q   <= drop_d;
      rr_q     <= rr_d;
    end
  end

  // Next-state
  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    goh_d    = goh_q;
    gvalid_d = gvalid_q;
    burst_d  = burst_q;
    gap_d    = gap_q;
    last_d   = last_q;
    txd_d    = txd_q;
    drop_d   = 1'b0;
    rr_d     = rr_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gid_d    = pick_idx;
          goh_d    = pick_oh;
          gvalid_d = 1'b1;
          burst_d  = '0;
          gap_d    = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        // A busy transmitter freezes the gap counter: a requester is not
        // penalised for the transmitter's backpressure.
        if (uart_tx_data_ready) begin
          if (sel_valid) begin
            txd_d   = req_data[gid_q];
            last_d  = req_last[gid_q];
            burst_d = burst_q + 1'b1;
            gap_d   = '0;
            state_d = SEND;
          end else if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
            drop_d  = 1'b1;
            state_d = RELEASE;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      SEND:      state_d = WAIT_ACC;
      WAIT_ACC:  if (!uart_tx_data_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (uart_tx_data_ready) begin
          if (last_q || burst_q == BURST_W'(MAX_BURST)) state_d = RELEASE;
          else                                          state_d = LOAD;
        end
      end
      RELEASE: begin
        rr_d     = gid_q;
        gvalid_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = accept ? goh_q : '0;
    uart_send    = (state_q == SEND);
    uart_tx_data = txd_q;
    grant_valid  = gvalid_q;
    grant_id     = gid_q;
    drop_timeout = drop_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N = 4;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_last  = '0;
  uart_data_t [N-1:0] req_data = '0;
  logic [N-1:0]     req_ready;
  uart_data_t       uart_tx_data;
  logic             uart_send;
  logic             uart_tx_data_ready;
  logic             grant_valid;
  logic [1:0]       grant_id;
  logic             drop_timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(4), .GAP_TIMEOUT(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .req_valid          (req_valid),
    .req_data           (req_data),
    .req_last           (req_last),
    .req_ready          (req_ready),
    .uart_tx_data       (uart_tx_data),
    .uart_send          (uart_send),
    .uart_tx_data_ready (uart_tx_data_ready),
    .grant_valid        (grant_valid),
    .grant_id           (grant_id),
    .drop_timeout       (drop_timeout)
  );

  int vecs = 0, miscmp = 0;
  int cyc = 0, sends = 0, drops = 0, rdys = 0;
  int last_send_cyc = 0, drop_cyc = 0;
  bit rdy_prev = 1'b0;
  logic [9:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vecs++;
    assert (got === want) else begin
      miscmp++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Transmitter: busy for 10 cycles after each send strobe.
  int   busy = 0;
  logic bp_hold = 1'b0;
  always @(posedge clk) begin
    if (uart_send)     busy <= 10;
    else if (busy != 0) busy <= busy - 1;
  end
  assign uart_tx_data_ready = (busy == 0) && !bp_hold;

  // Requesters: per-lane FIFO of {last,data}; head popped on accept.
  logic [8:0] rbuf [N][16];
  logic [3:0] wp [N];
  logic [3:0] rp [N];
  logic [N-1:0] en = '1;
  logic [N-1:0] acc;
  initial for (int i = 0; i < N; i++) begin wp[i] = '0; rp[i] = '0; end

  always begin
    @(posedge clk);
    acc = req_ready;
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && rp[i] != wp[i]) rp[i] = rp[i] + 4'd1;
      req_valid[i] = en[i] && (rp[i] != wp[i]);
      req_data[i]  = rbuf[i][rp[i]][7:0];
      req_last[i]  = rbuf[i][rp[i]][8];
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (req_ready != '0) begin
        rdys++;
        chk("rdy_onehot", 32'(req_ready), grant_valid ? (32'd1 << grant_id) : 32'd0);
      end
      if (uart_send) begin
        sends++;
        last_send_cyc = cyc;
        chk("send_after_rdy", 32'(rdy_prev), 32'd1);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_byte", {22'd0, grant_id, uart_tx_data}, {22'd0, e});
        end
      end
      if (drop_timeout) begin
        drops++;
        drop_cyc = cyc;
      end
      rdy_prev = (req_ready != '0);
    end else begin
      rdy_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [1:0] r, input logic [7:0] d, input logic l);
    rbuf[r][wp[r]] = {l, d};
    wp[r] = wp[r] + 4'd1;
  endtask

  task automatic expect_b(input logic [1:0] id, input logic [7:0] d);
    exp_q.push_back({id, d});
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    en = '1;
    bp_hold = 1'b0;
    for (int i = 0; i < N; i++) begin wp[i] = '0; rp[i] = '0; end
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_sends(input int n, input string tag);
    int k = 0;
    while (sends < n && k < 800) begin @(negedge clk); k++; end
    chk(tag, sends, n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (grant_valid && k < 100) begin @(negedge clk); k++; end
    chk(tag, 32'(grant_valid), 32'd0);
  endtask

  task automatic wait_drop(input int n, input string tag);
    int k = 0;
    while (drops < n && k < 100) begin @(negedge clk); k++; end
    chk(tag, drops, n);
  endtask

  initial begin
    int b, d0, r0, k;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_send",      32'(uart_send), 32'd0);
    chk("rst_txdata",    32'(uart_tx_data), 32'd0);
    chk("rst_gvalid",    32'(grant_valid), 32'd0);
    chk("rst_gid",       32'(grant_id), 32'd0);
    chk("rst_drop",      32'(drop_timeout), 32'd0);
    step();
    rst_n = 1'b1;

    // Single 3-byte frame on req0
    b = sends;
    push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
    expect_b(0, 8'h41); expect_b(0, 8'h42); expect_b(0, 8'h43);
    wait_sends(b + 3, "t1_sends");
    k = 0;
    while (grant_valid && k < 50) begin @(negedge clk); k++; end
    // SEND, WAIT_ACC, 10 busy cycles, then RELEASE and IDLE.
    chk("t1_release_lat", cyc - last_send_cyc, 13);
    chk("t1_sb_drained", exp_q.size(), 0);

    // Round-robin from a fresh pointer: 0,1,2,3 then 0,2
    do_reset();
    b = sends;
    for (int i = 0; i < N; i++) begin
      push(2'(i), 8'h10 + 8'(i), 1'b1);
      expect_b(2'(i), 8'h10 + 8'(i));
    end
    wait_sends(b + 4, "t2_sends_a");
    wait_idle("t2_idle");
    push(0, 8'h20, 1'b1); push(2, 8'h22, 1'b1);
    expect_b(0, 8'h20); expect_b(2, 8'h22);
    wait_sends(b + 6, "t2_sends_b");
    chk("t2_sb_drained", exp_q.size(), 0);

    // Burst cap of 4: req1 streams 10 unterminated bytes, req2 interleaves.
    // The stream's tail ends without a last byte, so the grant times out.
    do_reset();
    b = sends; d0 = drops;
    for (int j = 0; j < 10; j++) push(1, 8'h60 + 8'(j), 1'b0);
    push(2, 8'h5A, 1'b1);
    for (int j = 0; j < 4; j++) expect_b(1, 8'h60 + 8'(j));
    expect_b(2, 8'h5A);
    for (int j = 4; j < 10; j++) expect_b(1, 8'h60 + 8'(j));
    wait_sends(b + 11, "t3_sends");
    wait_drop(d0 + 1, "t3_drop");
    chk("t3_sb_drained", exp_q.size(), 0);

    // Gap timeout: req3 sends one unterminated byte and goes quiet; req0 waits.
    do_reset();
    en[0] = 1'b0;
    b = sends; d0 = drops;
    push(3, 8'h33, 1'b0); push(0, 8'h50, 1'b1);
    expect_b(3, 8'h33); expect_b(0, 8'h50);
    wait_sends(b + 1, "t4_first");
    en[0] = 1'b1;
    wait_drop(d0 + 1, "t4_drop");
    // LOAD re-entered 12 cycles after SEND; the pulse follows 8 LOAD cycles.
    chk("t4_drop_lat", drop_cyc - last_send_cyc, 20);
    wait_sends(b + 2, "t4_second");
    chk("t4_single_drop", drops, d0 + 1);
    chk("t4_sb_drained", exp_q.size(), 0);

    // Backpressure in LOAD: no accept, no send, gap counter frozen
    do_reset();
    bp_hold = 1'b1;
    push(1, 8'h77, 1'b1);
    expect_b(1, 8'h77);
    k = 0;
    while (!grant_valid && k < 20) begin @(negedge clk); k++; end
    chk("t5_granted", 32'(grant_valid), 32'd1);
    step();
    en[1] = 1'b0;
    b = sends; r0 = rdys; d0 = drops;
    repeat (20) step();
    chk("t5_no_timeout", drops, d0);
    chk("t5_still_granted", 32'(grant_valid), 32'd1);
    en[1] = 1'b1;
    repeat (10) step();
    chk("t5_no_ready", rdys, r0);
    chk("t5_no_send", sends, b);
    bp_hold = 1'b0;
    wait_sends(b + 1, "t5_send");

    // Reset in WAIT_DONE
    do_reset();
    b = sends;
    push(1, 8'h81, 1'b0); push(1, 8'h82, 1'b1);
    expect_b(1, 8'h81);
    wait_sends(b + 1, "t6_first");
    repeat (3) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("t6_req_ready", 32'(req_ready), 32'd0);
    chk("t6_send",      32'(uart_send), 32'd0);
    chk("t6_txdata",    32'(uart_tx_data), 32'd0);
    chk("t6_gvalid",    32'(grant_valid), 32'd0);
    chk("t6_gid",       32'(grant_id), 32'd0);
    chk("t6_drop",      32'(drop_timeout), 32'd0);
    step();
    push(0, 8'h90, 1'b1);
    expect_b(0, 8'h90); expect_b(1, 8'h82);
    step();
    rst_n = 1'b1;
    wait_sends(b + 3, "t6_after");
    chk("t6_sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
